demux_router: RTL and testbench



---
 rtl/demux_pkg.sv | 32 +++
 rtl/demux_slot.sv | 66 ++++++
 rtl/demux_router.sv | 65 ++++++
 tb/tb_demux_router.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and select decode for the 1-to-4 registered demux router.
// The optional delivery counters are enabled with DEMUX_COUNT_EN.
package demux_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int NUM_OUT   = 4;
    localparam int DEF_CNT_W = 8;

    localparam logic [1:0] SEL_A0 = 2'b00;
    localparam logic [1:0] SEL_A1 = 2'b01;
    localparam logic [1:0] SEL_A2 = 2'b10;
    localparam logic [1:0] SEL_A3 = 2'b11;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [NUM_OUT-1:0] sel_decode(input logic [1:0] sel);
        logic [NUM_OUT-1:0] onehot;
        onehot = '0;
        case (sel)
            SEL_A0: onehot = 4'b0001;
            SEL_A1: onehot = 4'b0010;
            SEL_A2: onehot = 4'b0100;
            SEL_A3: onehot = 4'b1000;
            default: onehot = '0;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot with valid/ready handshake on its output side.
// With DEMUX_COUNT_EN defined it also counts drain events, saturating.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef DEMUX_COUNT_EN
    , parameter int CNT_W = DEF_CNT_W
`endif
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready
`ifdef DEMUX_COUNT_EN
    , output logic [CNT_W-1:0] cnt
`endif
);

    slot_state_e state;

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    // NOTE: the data register is reset as well, because consumers see A0..A3
    // read as zero coming out of reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= SLOT_EMPTY;
            data  <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: begin
                    if (load) begin
                        state <= SLOT_FULL;
                        data  <= data_in;
                    end
                end
                SLOT_FULL: begin
                    // A load on the draining edge replaces the word in place.
                    if (load) begin
                        data <= data_in;
                    end else if (ready) begin
                        state <= SLOT_EMPTY;
                    end
                end
                default: state <= SLOT_EMPTY;
            endcase
        end
    end

    assign valid = (state == SLOT_FULL);

`ifdef DEMUX_COUNT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (valid && ready && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux_router.sv
// 1-to-4 registered demultiplexer: routes C to slot {SEL1,SEL2}, each slot
// drained independently. DEMUX_COUNT_EN adds per-channel DELIV_CNT counters.
module demux_router
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [WIDTH-1:0]   C,
  input  logic               SEL1,
  input  logic               SEL2,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic [WIDTH-1:0]   A0,
  output logic [WIDTH-1:0]   A1,
  output logic [WIDTH-1:0]   A2,
  output logic [WIDTH-1:0]   A3,
  output logic [NUM_OUT-1:0] A_VALID,
  input  logic [NUM_OUT-1:0] A_READY
`ifdef DEMUX_COUNT_EN
  , output logic [NUM_OUT*CNT_W-1:0] DELIV_CNT
`endif
);

  logic [1:0]         sel;
  logic               accept;
  logic [NUM_OUT-1:0] load;
  logic [WIDTH-1:0]   slot_data [NUM_OUT];

  assign sel = {SEL1, SEL2};

  // Only the destination slot gates the producer; other full slots never do.
  // Ready is held low in reset so nothing is offered into slots being cleared.
  assign IN_READY = RST_N & (~A_VALID[sel] | A_READY[sel]);
  assign accept   = IN_VALID & IN_READY;
  assign load     = sel_decode(sel) & {NUM_OUT{accept}};

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
`ifdef DEMUX_COUNT_EN
      , .CNT_W (CNT_W)
`endif
    ) u_slot (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .load    (load[i]),
      .data_in (C),
      .data    (slot_data[i]),
      .valid   (A_VALID[i]),
      .ready   (A_READY[i])
`ifdef DEMUX_COUNT_EN
      , .cnt   (DELIV_CNT[i*CNT_W +: CNT_W])
`endif
    );
  end

  assign A0 = slot_data[0];
  assign A1 = slot_data[1];
  assign A2 = slot_data[2];
  assign A3 = slot_data[3];

endmodule

// File: tb/tb_demux_router.sv
// Self-checking bench for demux_router: directed scenarios plus randomized
// traffic against a slot-level reference model; DEMUX_COUNT_EN adds counter checks.
module tb_demux_router;

  localparam int W       = 32;
  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic         CLK      = 1'b0;
  logic         RST_N    = 1'b1;
  logic [W-1:0] C        = '0;
  logic         SEL1     = 1'b0;
  logic         SEL2     = 1'b0;
  logic         IN_VALID = 1'b0;
  logic [3:0]   A_READY  = 4'b0000;
  wire          IN_READY;
  wire  [W-1:0] A0, A1, A2, A3;
  wire  [3:0]   A_VALID;
`ifdef DEMUX_COUNT_EN
  wire  [4*CW-1:0] DELIV_CNT;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one word per channel plus its delivery count.
  bit           mv   [4];
  logic [W-1:0] md   [4];
  int           mcnt [4];
  bit           pend;
  logic [1:0]   pend_sel;

  demux_router #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .C        (C),
    .SEL1     (SEL1),
    .SEL2     (SEL2),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .A0       (A0),
    .A1       (A1),
    .A2       (A2),
    .A3       (A3),
    .A_VALID  (A_VALID),
    .A_READY  (A_READY)
`ifdef DEMUX_COUNT_EN
    , .DELIV_CNT (DELIV_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic bit model_ready();
    logic [1:0] d;
    d = {SEL1, SEL2};
    return RST_N && (!mv[d] || A_READY[d]);
  endfunction

  function automatic logic [W-1:0] dut_word(input logic [1:0] i);
    case (i)
      2'd0:    return A0;
      2'd1:    return A1;
      2'd2:    return A2;
      default: return A3;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mv[i]   = 1'b0;
      md[i]   = '0;
      mcnt[i] = 0;
    end
    pend = 1'b0;
  endtask

  // Advance one rising edge, applying the routing rules to the model.
  task automatic tick();
    bit         rdy;
    bit         acc;
    logic [1:0] d;
    @(posedge CLK);
    if (!RST_N) begin
      model_clear();
    end else begin
      d   = {SEL1, SEL2};
      rdy = model_ready();
      if (pend && IN_VALID) begin
        n_checks++;
        if (d !== pend_sel) begin
          n_fail++;
          $display("FAIL protocol_sel_hold: sel=%0d while pending word targets %0d", d, pend_sel);
        end
      end
      acc = IN_VALID && rdy;
      for (int i = 0; i < 4; i++) begin
        if (mv[i] && A_READY[i]) begin
`ifdef DEMUX_COUNT_EN
          if (mcnt[i] < CNT_MAX) mcnt[i]++;
`else
          mcnt[i]++;
`endif
          if (!(acc && d == 2'(i))) mv[i] = 1'b0;
        end
      end
      if (acc) begin
        mv[d] = 1'b1;
        md[d] = C;
      end
      pend     = IN_VALID && !rdy;
      pend_sel = d;
    end
    #1;
  endtask

  task automatic test_reset();
    #1 RST_N = 1'b0;
    #2;
    n_checks++;
    if (A_VALID !== 4'b0000) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0000", A_VALID);
    end
    n_checks++;
    if ({A3, A2, A1, A0} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {A3, A2, A1, A0});
    end
    n_checks++;
    if (IN_READY !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 0", IN_READY);
    end
    model_clear();
    @(negedge CLK) RST_N = 1'b1;
    tick();

    // Load two channels, stall a third word, then reset mid-transfer.
    A_READY = 4'b0000;
    IN_VALID = 1'b1; {SEL1, SEL2} = 2'b01; C = 32'hA5A5_0001;
    tick();
    {SEL1, SEL2} = 2'b10; C = 32'hA5A5_0002;
    tick();
    n_checks++;
    if (A_VALID !== 4'b0110) begin
      n_fail++; $display("FAIL reset_preload: got %b expected 0110", A_VALID);
    end
    {SEL1, SEL2} = 2'b01; C = 32'hA5A5_0003;
    #1 RST_N = 1'b0;
    #1;
    n_checks++;
    if (A_VALID !== 4'b0000 || {A3, A2, A1, A0} !== '0) begin
      n_fail++; $display("FAIL reset_mid_clear: got valid=%b data=%h expected 0000/0", A_VALID, {A3, A2, A1, A0});
    end
    n_checks++;
    if (IN_READY !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_in_ready: got %b expected 0", IN_READY);
    end
    model_clear();
    IN_VALID = 1'b0;
    A_READY  = 4'b1111;
    @(negedge CLK) RST_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (A_VALID !== 4'b0000) begin
        n_fail++; $display("FAIL reset_no_emit: got %b expected 0000", A_VALID);
      end
    end
  endtask

  task automatic test_routing();
    logic [1:0]   sels [4];
    logic [W-1:0] vals [4];
    sels = '{2'b11, 2'b10, 2'b01, 2'b00};
    vals = '{32'd3, 32'd2, 32'd3, 32'd2};
    A_READY = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      IN_VALID = 1'b1; {SEL1, SEL2} = sels[k]; C = vals[k];
      #1;
      n_checks++;
      if (IN_READY !== 1'b1) begin
        n_fail++; $display("FAIL route_in_ready: got %b expected 1 (sel=%0d)", IN_READY, sels[k]);
      end
      tick();
      n_checks++;
      if (A_VALID !== (4'b0001 << sels[k])) begin
        n_fail++; $display("FAIL route_valid: got %b expected %b", A_VALID, 4'b0001 << sels[k]);
      end
      n_checks++;
      if (dut_word(sels[k]) !== vals[k]) begin
        n_fail++; $display("FAIL route_word: A%0d got %h expected %h", sels[k], dut_word(sels[k]), vals[k]);
      end
    end
    IN_VALID = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    A_READY = 4'b1011;
    IN_VALID = 1'b1; {SEL1, SEL2} = 2'b10; C = 32'd2;
    #1;
    n_checks++;
    if (IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL stall_first_ready: got %b expected 1", IN_READY);
    end
    tick();
    C = 32'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (IN_READY !== 1'b0) begin
        n_fail++; $display("FAIL stall_in_ready: got %b expected 0", IN_READY);
      end
      tick();
      n_checks++;
      if (A_VALID[2] !== 1'b1 || A2 !== 32'd2) begin
        n_fail++; $display("FAIL stall_hold: got valid=%b A2=%h expected 1/2", A_VALID[2], A2);
      end
    end
    IN_VALID = 1'b0;
    tick();
  endtask

  task automatic test_independence();
    IN_VALID = 1'b1; {SEL1, SEL2} = 2'b01; C = 32'd3;
    #1;
    n_checks++;
    if (IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL indep_in_ready: got %b expected 1", IN_READY);
    end
    tick();
    n_checks++;
    if (A_VALID[1] !== 1'b1 || A1 !== 32'd3 || A_VALID[2] !== 1'b1 || A2 !== 32'd2) begin
      n_fail++; $display("FAIL indep_words: got valid=%b A1=%h A2=%h expected x11x/3/2", A_VALID, A1, A2);
    end
    IN_VALID = 1'b0;
    tick();
  endtask

  task automatic test_stall_release();
    IN_VALID = 1'b1; {SEL1, SEL2} = 2'b10; C = 32'd7;
    #1;
    n_checks++;
    if (IN_READY !== 1'b0) begin
      n_fail++; $display("FAIL release_blocked: got %b expected 0", IN_READY);
    end
    tick();
    A_READY = 4'b1111;
    #1;
    n_checks++;
    if (IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL release_ready: got %b expected 1", IN_READY);
    end
    tick();
    n_checks++;
    if (A_VALID[2] !== 1'b1 || A2 !== 32'd7) begin
      n_fail++; $display("FAIL release_word: got valid=%b A2=%h expected 1/7", A_VALID[2], A2);
    end
    IN_VALID = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    A_READY = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      IN_VALID = 1'b1; {SEL1, SEL2} = 2'b00; C = W'(k);
      #1;
      n_checks++;
      if (IN_READY !== 1'b1) begin
        n_fail++; $display("FAIL b2b_in_ready: got %b expected 1 at word %0d", IN_READY, k);
      end
      tick();
      n_checks++;
      if (A_VALID[0] !== 1'b1 || A0 !== W'(k)) begin
        n_fail++; $display("FAIL b2b_word: got valid=%b A0=%h expected 1/%h", A_VALID[0], A0, W'(k));
      end
    end
    IN_VALID = 1'b0;
    A_READY  = 4'b1111;
    tick();
  endtask

`ifdef DEMUX_COUNT_EN
  task automatic test_count();
    RST_N = 1'b0;
    #1;
    model_clear();
    @(negedge CLK) RST_N = 1'b1;
    tick();
    A_READY = 4'b1000;
    for (int k = 1; k <= 5; k++) begin
      IN_VALID = 1'b1; {SEL1, SEL2} = 2'b11; C = W'(k);
      tick();
    end
    IN_VALID = 1'b0;
    tick();
    tick();
    n_checks++;
    if (DELIV_CNT !== {2'd3, 2'd0, 2'd0, 2'd0}) begin
      n_fail++; $display("FAIL count_saturate: got %b expected 11000000", DELIV_CNT);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0]   exp_valid;
    logic [W-1:0] exp_data [4];
`ifdef DEMUX_COUNT_EN
    logic [4*CW-1:0] exp_cnt;
`endif
    for (int n = 0; n < 400; n++) begin
      if (!pend) begin
        IN_VALID     = ($urandom_range(0, 3) != 0);
        {SEL1, SEL2} = 2'($urandom_range(0, 3));
        C            = $urandom;
      end
      A_READY = 4'($urandom_range(0, 15));
      #1;
      n_checks++;
      if (IN_READY !== model_ready()) begin
        n_fail++; $display("FAIL rand_in_ready: cycle %0d got %b expected %b", n, IN_READY, model_ready());
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        exp_valid[i] = mv[i];
        exp_data[i]  = md[i];
      end
      n_checks++;
      if (A_VALID !== exp_valid) begin
        n_fail++; $display("FAIL rand_valid: cycle %0d got %b expected %b", n, A_VALID, exp_valid);
      end
      n_checks++;
      if ({A3, A2, A1, A0} !== {exp_data[3], exp_data[2], exp_data[1], exp_data[0]}) begin
        n_fail++; $display("FAIL rand_data: cycle %0d got %h expected %h", n, {A3, A2, A1, A0},
                           {exp_data[3], exp_data[2], exp_data[1], exp_data[0]});
      end
`ifdef DEMUX_COUNT_EN
      for (int i = 0; i < 4; i++) exp_cnt[i*CW +: CW] = CW'(mcnt[i]);
      n_checks++;
      if (DELIV_CNT !== exp_cnt) begin
        n_fail++; $display("FAIL rand_count: cycle %0d got %b expected %b", n, DELIV_CNT, exp_cnt);
      end
`endif
    end
    IN_VALID = 1'b0;
    tick();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_routing();
    test_stall();
    test_independence();
    test_stall_release();
    test_back_to_back();
`ifdef DEMUX_COUNT_EN
    test_count();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
